stopwatch_input_conditioner: RTL and testbench
==============================================

# stopwatch_input_conditioner

Front-end stage between the board pins and the stopwatch counter. It synchronises the raw pause/reset buttons and the SEL/ADJ switches to `clk`, debounces both buttons on a periodic sample strobe, and converts them into a registered pause level and a single-cycle user-reset pulse. `countMod` and `displayMod` consume these in place of the raw `btnS`/`btnR`/`sw` signals.

## Interface
- `STABLE_SAMPLES`, default 4: number of consecutive differing sample ticks required to accept a button change. Legal range is 2..255.
- `clk` input 1: master clock.
- `rst` input 1: synchronous, active-high system reset.
- `sample_en` input 1: one-`clk`-wide debounce sample strobe, nominally ~1 kHz, derived from `clockMod`.
- `btn_pause_raw` input 1: raw pause button (`btnS`), asynchronous.
- `btn_reset_raw` input 1: raw reset button (`btnR`), asynchronous.
- `sw_raw` input 2: raw switches. Bit [0] is SEL, bit [1] is ADJ. Asynchronous.
- `pause` output 1: registered pause state fed to the counter.
- `user_rst` output 1: one-`clk` pulse per accepted reset-button press.
- `sel` output 1: synchronised `sw_raw[0]`.
- `adj` output 1: synchronised `sw_raw[1]`.

## Operation
- **Synchronisers.** Each of the 4 raw inputs passes through a 2-flop synchroniser. All synchroniser flops reset to 0.
- **Per-button FSM.** Each button has an FSM with states RELEASED, PRESS_PEND, PRESSED and RELEASE_PEND, plus a sample counter of width $clog2(STABLE_SAMPLES+1).
  - RELEASED: on a `sample_en` tick with the synced input = 1, set cnt=1 and go to PRESS_PEND.
  - PRESS_PEND: on a tick with input = 1, increment cnt. When cnt reaches STABLE_SAMPLES, go to PRESSED and raise the press event. On a tick with input = 0, clear cnt and return to RELEASED. Glitches are rejected; no event is raised.
  - PRESSED and RELEASE_PEND: mirror image of the above with input = 0. No event is raised on release.
  - Between ticks, neither the state nor cnt changes.
- **Press event.** Raised on the cycle the FSM enters PRESSED.
- **`user_rst`.** Registered copy of the reset-button press event. High for exactly 1 cycle.
- **`pause`.** On a pause press event, `pause` toggles. On a reset press event, `pause` clears to 0.
- **Simultaneous events.** If both press events occur in the same cycle, reset wins: `pause` becomes 0 and `user_rst` pulses.
- **Holding a button.** A held button produces exactly one event. The next event requires a full release (RELEASE_PEND completed) followed by a new press.
- **Switches.** `sel` and `adj` are synchronised only, not debounced. They change freely in any pause state.
- **`rst` mid-operation.** All FSMs return to RELEASED, counters clear to 0, `pause`=0 and `user_rst`=0. A button still held after `rst` deasserts re-qualifies as a new press after STABLE_SAMPLES ticks.

## Timing
- **Reset values.** `pause`=0, `user_rst`=0, `sel`=0, `adj`=0.
- **Synchroniser latency.** 2 `clk` cycles from raw input to synced value.
- **Press latency.** Raw edge to accepted press is 2 `clk` cycles plus STABLE_SAMPLES `sample_en` ticks.
  - `user_rst` is high in the cycle after the qualifying tick cycle.
  - `pause` updates in that same cycle.
- **Switch latency.** `sel`/`adj` follow `sw_raw` with exactly 2 cycles of latency.
- **`sample_en` held high continuously.** Legal. Debounce then counts `clk` cycles.
- **`sample_en` coincident with `rst`.** `rst` has priority and the tick is ignored.

## Configuration
- Macro: `STOPWATCH_PAUSE_TOGGLE_EN`.
- **Defined.** `pause` is a toggle latch as described in Operation.
- **Undefined.** `pause` = 1 while the pause FSM is in PRESSED or RELEASE_PEND, else 0. This is a debounced level (hold-to-pause). A reset press has no effect on `pause`. `user_rst` behaviour is unchanged.

## Structure
- **Shared package `stopwatch_pkg`:**
  - `btn_state_t` enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND).
  - `SW_SEL_IDX`=0 and `SW_ADJ_IDX`=1.
  - `DEFAULT_STABLE_SAMPLES`=4.
- **Sub-module `btn_debounce`.**
  - Contains the synchroniser, FSM and counter.
  - Outputs `level` and `press_evt`.
  - Instantiated twice, once per button.
- **Top of this block:** the pause latch, the `user_rst` register and the switch synchronisers.

## Test plan
1. **Clean press.** `btn_pause_raw` 0→1, held for 10 ticks with STABLE_SAMPLES=4 → `pause` 0→1 exactly 1 cycle after the 4th tick. No further change while held.
2. **Bounce.** Pause input pattern 1,0,1,1,0 across consecutive ticks, then 0 → `pause` stays 0 and the FSM returns to RELEASED.
3. **Two full press/release cycles on pause** → `pause` goes 0→1→0. `user_rst` never asserts.
4. **Reset button.** Press while `pause`=1 → `user_rst` high for exactly 1 cycle and `pause`=0 in the same cycle. Holding for 20 further ticks gives no second pulse.
5. **Simultaneous press.** Both buttons qualify on the same tick → `user_rst`=1 and `pause`=0.
6. **Reset during PRESS_PEND.** Assert `rst` while the pause FSM is in PRESS_PEND (cnt=3) → all outputs 0 on the next cycle. With the button still held, `pause`=1 after 4 more ticks.
   - Also drive `sw_raw`=2'b10 → `adj`=1 and `sel`=0 exactly 2 cycles later.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input conditioner.
//   btn_state_t            : debounce FSM state encoding
//   SW_SEL_IDX/SW_ADJ_IDX  : bit positions of SEL and ADJ within sw_raw
//   DEFAULT_STABLE_SAMPLES : default number of agreeing sample ticks
package stopwatch_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } btn_state_t;

   localparam int SW_SEL_IDX = 0;
   localparam int SW_ADJ_IDX = 1;

   localparam int unsigned DEFAULT_STABLE_SAMPLES = 4;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser followed by a debounce FSM
// that only advances on sample_en ticks.
//   clk, rst   : clock, synchronous active-high reset
//   sample_en  : debounce sample strobe
//   btn_raw    : asynchronous raw button
//   level      : debounced level (PRESSED or RELEASE_PEND)
//   press_evt  : high in the cycle whose tick completes a press
//
// state        | meaning
// RELEASED     | button idle, waiting for a tick with input high
// PRESS_PEND   | counting consecutive high ticks toward a press
// PRESSED      | press accepted, waiting for a tick with input low
// RELEASE_PEND | counting consecutive low ticks toward a release
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic btn_raw,
   output logic level,
   output logic press_evt
);

   localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);
   // Compare against S-1 so the increment never has to represent S itself.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   logic [1:0]       sync_q;
   logic             btn_sync;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign btn_sync = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b00;
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw};
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      if (sample_en) begin
         case (state_q)
            RELEASED: begin
               if (btn_sync) begin
                  state_d = PRESS_PEND;
                  cnt_d   = CNT_W'(1);
               end
            end
            PRESS_PEND: begin
               if (btn_sync) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d   = PRESSED;
                     cnt_d     = '0;
                     press_evt = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end
            end
            PRESSED: begin
               if (!btn_sync) begin
                  state_d = RELEASE_PEND;
                  cnt_d   = CNT_W'(1);
               end
            end
            RELEASE_PEND: begin
               if (!btn_sync) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = RELEASED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = RELEASED;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign level = (state_q == PRESSED) || (state_q == RELEASE_PEND);

endmodule

// File: rtl/stopwatch_input_conditioner.sv
// Stopwatch front end: debounces the pause and reset buttons, produces the
// pause level and a one-cycle user reset pulse, and synchronises SEL/ADJ.
//   clk, rst       : clock, synchronous active-high reset
//   sample_en      : debounce sample strobe
//   btn_pause_raw  : raw pause button
//   btn_reset_raw  : raw reset button
//   sw_raw[1:0]    : raw switches, [0]=SEL, [1]=ADJ
//   pause          : pause state for the counter
//   user_rst       : one-cycle pulse per accepted reset press
//   sel, adj       : synchronised switches
// Build option STOPWATCH_PAUSE_TOGGLE_EN: when defined, pause toggles on each
// pause press and is cleared by a reset press; otherwise pause is the
// debounced hold level of the pause button.
module stopwatch_input_conditioner
   import stopwatch_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_en,
   input  logic       btn_pause_raw,
   input  logic       btn_reset_raw,
   input  logic [1:0] sw_raw,
   output logic       pause,
   output logic       user_rst,
   output logic       sel,
   output logic       adj
);

   logic       pause_level, pause_evt;
   logic       reset_level, reset_evt;
   logic [1:0] sw_sync1_q, sw_sync2_q;
   logic       user_rst_q;
   logic       unused_sigs;

   btn_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_pause_db (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .btn_raw   (btn_pause_raw),
      .level     (pause_level),
      .press_evt (pause_evt)
   );

   btn_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_reset_db (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .btn_raw   (btn_reset_raw),
      .level     (reset_level),
      .press_evt (reset_evt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_sync1_q <= 2'b00;
         sw_sync2_q <= 2'b00;
         user_rst_q <= 1'b0;
      end else begin
         sw_sync1_q <= sw_raw;
         sw_sync2_q <= sw_sync1_q;
         user_rst_q <= reset_evt;
      end
   end

`ifdef STOPWATCH_PAUSE_TOGGLE_EN
   logic pause_q, pause_d;

   // Reset press takes priority over a pause press landing on the same tick.
   always_comb begin
      pause_d = pause_q;
      if (reset_evt) begin
         pause_d = 1'b0;
      end else if (pause_evt) begin
         pause_d = ~pause_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pause_q <= 1'b0;
      end else begin
         pause_q <= pause_d;
      end
   end

   assign pause       = pause_q;
   assign unused_sigs = ^{pause_level, reset_level};
`else
   assign pause       = pause_level;
   assign unused_sigs = ^{pause_evt, reset_level};
`endif

   assign user_rst = user_rst_q;
   assign sel      = sw_sync2_q[SW_SEL_IDX];
   assign adj      = sw_sync2_q[SW_ADJ_IDX];

endmodule

// File: tb/tb_stopwatch_input_conditioner.sv
module tb_stopwatch_input_conditioner;

   localparam int S = 4;
`ifdef STOPWATCH_PAUSE_TOGGLE_EN
   localparam bit TOG = 1'b1;
`else
   localparam bit TOG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, se, pr, rr;
   logic [1:0] sw;
   logic       pause, user_rst, sel, adj;

   int n_tests = 0;
   int n_fail  = 0;

   stopwatch_input_conditioner #(.STABLE_SAMPLES(S)) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_en     (se),
      .btn_pause_raw (pr),
      .btn_reset_raw (rr),
      .sw_raw        (sw),
      .pause         (pause),
      .user_rst      (user_rst),
      .sel           (sel),
      .adj           (adj)
   );

   always #5 clk = ~clk;

   // Reference model: each button holds an accepted level and a run length
   // of consecutive ticks disagreeing with it; S disagreeing ticks flip it.
   bit m_s1[4], m_s2[4];   // sync pipeline: 0 pause, 1 reset, 2 sel, 3 adj
   bit m_acc[2];
   int m_run[2];
   bit m_pause, m_urst;

   task automatic model_edge();
      bit evt[2];
      if (rst) begin
         for (int i = 0; i < 4; i++) begin m_s1[i] = 0; m_s2[i] = 0; end
         for (int b = 0; b < 2; b++) begin m_acc[b] = 0; m_run[b] = 0; end
         m_pause = 0;
         m_urst  = 0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            evt[b] = 0;
            if (se) begin
               if (m_s2[b] != m_acc[b]) begin
                  m_run[b]++;
                  if (m_run[b] == S) begin
                     m_acc[b] = m_s2[b];
                     m_run[b] = 0;
                     evt[b]   = m_acc[b];
                  end
               end else begin
                  m_run[b] = 0;
               end
            end
         end
         m_urst = evt[1];
         if (TOG) begin
            if (evt[1]) m_pause = 0;
            else if (evt[0]) m_pause = !m_pause;
         end else begin
            m_pause = m_acc[0];
         end
         for (int i = 0; i < 4; i++) m_s2[i] = m_s1[i];
         m_s1[0] = pr; m_s1[1] = rr; m_s1[2] = sw[0]; m_s1[3] = sw[1];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Holds the raw buttons for three cycles with a tick on the last one,
   // so the FSM sees exactly the given level at that tick.
   task automatic tick(input bit p, input bit r);
      pr = p; rr = r; se = 0;
      cyc(); cyc();
      se = 1;
      cyc();
      se = 0;
   endtask

   task automatic do_rst();
      rst = 1; se = 0; pr = 0; rr = 0;
      cyc(); cyc();
      rst = 0;
   endtask

   typedef struct {
      bit       rst;
      bit       pr;
      bit       rr;
      bit       se;
      bit [1:0] sw;
      bit [3:0] exp;   // {pause, user_rst, sel, adj}
   } vec_t;

   vec_t tbl[12];

   initial begin
      bit [3:0] exp_v;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 4'b0000};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0010};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0010};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0010};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0010};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b1010};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'b1010};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'b1001};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b1001};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b1001};

      rst = 1; se = 0; pr = 0; rr = 0; sw = 2'b00;

      // Table: reset, switch latency, clean press with sample_en held high.
      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; pr = tbl[i].pr; rr = tbl[i].rr;
         se  = tbl[i].se;  sw = tbl[i].sw;
         cyc();
         chk($sformatf("table row %0d", i), {pause, user_rst, sel, adj}, tbl[i].exp);
      end

      // Bounce rejection, then a full qualifying press.
      do_rst();
      sw = 2'b00;
      chk("after rst", {pause, user_rst, sel, adj}, 4'b0000);
      tick(1, 0); chk("bounce t1", {3'b0, pause}, 4'd0);
      tick(0, 0); chk("bounce t2", {3'b0, pause}, 4'd0);
      tick(1, 0); chk("bounce t3", {3'b0, pause}, 4'd0);
      tick(1, 0); chk("bounce t4", {3'b0, pause}, 4'd0);
      tick(0, 0); chk("bounce t5", {3'b0, pause}, 4'd0);
      tick(0, 0); chk("bounce t6", {3'b0, pause}, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick(1, 0); chk($sformatf("press1 t%0d", i + 1), {3'b0, pause}, 4'd0);
      end
      tick(1, 0); chk("press1 done", {2'b0, pause, user_rst}, 4'b0010);

      // Release and a second press.
      for (int i = 0; i < 3; i++) begin
         tick(0, 0); chk($sformatf("rel1 t%0d", i + 1), {3'b0, pause}, 4'd1);
      end
      tick(0, 0); chk("rel1 done", {3'b0, pause}, {3'b0, TOG});
      for (int i = 0; i < 3; i++) begin
         tick(1, 0); chk($sformatf("press2 t%0d", i + 1), {3'b0, pause}, {3'b0, TOG});
      end
      tick(1, 0); chk("press2 done", {2'b0, pause, user_rst}, {2'b0, !TOG, 1'b0});

      for (int i = 0; i < 4; i++) tick(0, 0);
      chk("rel2 done", {3'b0, pause}, 4'd0);
      for (int i = 0; i < 4; i++) tick(1, 0);
      chk("press3 done", {3'b0, pause}, 4'd1);

      // Reset button pressed while paused, then held.
      for (int i = 0; i < 3; i++) begin
         tick(1, 1); chk($sformatf("rbtn t%0d", i + 1), {2'b0, pause, user_rst}, 4'b0010);
      end
      tick(1, 1); chk("rbtn qualify", {2'b0, pause, user_rst}, {2'b0, !TOG, 1'b1});
      cyc();      chk("rbtn pulse end", {3'b0, user_rst}, 4'd0);
      for (int i = 0; i < 20; i++) begin
         tick(1, 1);
         chk($sformatf("rbtn hold %0d", i), {2'b0, pause, user_rst}, {2'b0, !TOG, 1'b0});
      end

      // Simultaneous press of both buttons.
      for (int i = 0; i < 4; i++) tick(0, 0);
      chk("both released", {2'b0, pause, user_rst}, 4'b0000);
      for (int i = 0; i < 3; i++) tick(1, 1);
      chk("both pend", {3'b0, user_rst}, 4'd0);
      tick(1, 1); chk("both qualify", {2'b0, pause, user_rst}, {2'b0, !TOG, 1'b1});

      // rst while the pause FSM sits in PRESS_PEND with cnt=3.
      do_rst();
      sw = 2'b00;
      for (int i = 0; i < 3; i++) tick(1, 0);
      chk("pend before rst", {3'b0, pause}, 4'd0);
      rst = 1; se = 1; sw = 2'b10; pr = 1;
      cyc();
      chk("mid rst outputs", {pause, user_rst, sel, adj}, 4'b0000);
      rst = 0; se = 0;
      cyc(); chk("sw lat 1", {2'b0, sel, adj}, 4'b0000);
      cyc(); chk("sw lat 2", {2'b0, sel, adj}, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         tick(1, 0); chk($sformatf("requal t%0d", i + 1), {3'b0, pause}, 4'd0);
      end
      tick(1, 0); chk("requal done", {3'b0, pause}, 4'd1);

      // Randomised stimulus against the reference model.
      do_rst();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) pr = !pr;
         if ($urandom_range(7) == 0) rr = !rr;
         if ($urandom_range(3) == 0) sw = 2'($urandom_range(3));
         se  = ($urandom_range(2) == 0);
         rst = ($urandom_range(399) == 0);
         cyc();
         exp_v = {m_pause, m_urst, m_s2[2], m_s2[3]};
         chk($sformatf("random cyc %0d", i), {pause, user_rst, sel, adj}, exp_v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
